// File: rtl/df_qp_edge_seq.sv
// Deblocking-filter edge sequencer: walks the MB edges in filter order and presents qPav/indexA/indexB per edge.
// Build option: define DF_QP_CHROMA_EDGES_EN to emit the four chroma edges as well (default: 8 luma edges only).
module df_qp_edge_seq (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_of_MB_DF,
    input  logic [5:0] QPy,
    input  logic [5:0] QPc,
    input  logic [5:0] QPy_addrA,
    input  logic [5:0] QPc_addrA,
    input  logic [5:0] QPy_addrB,
    input  logic [5:0] QPc_addrB,
    input  logic [7:0] mb_num_h_DF,
    input  logic [7:0] mb_num_v_DF,
    input  logic [1:0] disable_deblocking_filter_idc,
    input  logic [4:0] FilterOffsetA,
    input  logic [4:0] FilterOffsetB,
    input  logic       edge_ready,
    output logic       edge_valid,
    output logic       edge_dir,
    output logic [1:0] edge_idx,
    output logic       edge_chroma,
    output logic [5:0] qPav,
    output logic [5:0] indexA,
    output logic [5:0] indexB,
    output logic       edge_filter_en,
    output logic       busy,
    output logic       end_of_MB_DF
);

    typedef enum logic [1:0] {IDLE, LOAD, EDGE, DONE} state_t;

    typedef struct packed {
        logic [5:0] qpy;
        logic [5:0] qpc;
        logic [5:0] qpy_a;
        logic [5:0] qpc_a;
        logic [5:0] qpy_b;
        logic [5:0] qpc_b;
        logic       h_zero;
        logic       v_zero;
        logic [1:0] idc;
        logic [4:0] off_a;
        logic [4:0] off_b;
    } cfg_t;

`ifdef DF_QP_CHROMA_EDGES_EN
    localparam logic [3:0] LAST_EDGE = 4'd11;
    localparam logic       CHROMA_EN = 1'b1;
`else
    localparam logic [3:0] LAST_EDGE = 4'd7;
    localparam logic       CHROMA_EN = 1'b0;
`endif

    function automatic logic [5:0] clip_index(input logic [5:0] qp, input logic [4:0] offset);
        logic signed [7:0] idx_sum;
        idx_sum = $signed({2'b00, qp}) + $signed({{3{offset[4]}}, offset});
        if (idx_sum < 8'sd0)       clip_index = 6'd0;
        else if (idx_sum > 8'sd51) clip_index = 6'd51;
        else                       clip_index = idx_sum[5:0];
    endfunction

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    cfg_t       cfg_q, cfg_d;

    logic       edge_valid_q, edge_valid_d;
    logic       edge_dir_q, edge_dir_d;
    logic [1:0] edge_idx_q, edge_idx_d;
    logic       edge_chroma_q, edge_chroma_d;
    logic [5:0] qpav_q, qpav_d;
    logic [5:0] index_a_q, index_a_d;
    logic [5:0] index_b_q, index_b_d;
    logic       filter_en_q, filter_en_d;
    logic       busy_q, busy_d;
    logic       end_q, end_d;

    logic       handshake;
    logic       is_chroma;
    logic [5:0] qpp, qpq;
    logic [6:0] qp_sum;
    logic       first_vert, first_horz;

    assign handshake = edge_valid_q && edge_ready;

    // NOTE: every variable assigned in an always_comb gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cfg_d   = cfg_q;
        case (state_q)
            IDLE: if (start_of_MB_DF) state_d = LOAD;
            LOAD: begin
                cfg_d.qpy    = QPy;
                cfg_d.qpc    = QPc;
                cfg_d.qpy_a  = QPy_addrA;
                cfg_d.qpc_a  = QPc_addrA;
                cfg_d.qpy_b  = QPy_addrB;
                cfg_d.qpc_b  = QPc_addrB;
                cfg_d.h_zero = (mb_num_h_DF == 8'd0);
                cfg_d.v_zero = (mb_num_v_DF == 8'd0);
                cfg_d.idc    = disable_deblocking_filter_idc;
                cfg_d.off_a  = FilterOffsetA;
                cfg_d.off_b  = FilterOffsetB;
                cnt_d        = 4'd0;
                state_d      = EDGE;
            end
            EDGE: begin
                if (handshake) begin
                    if (cnt_q == LAST_EDGE) begin
                        cnt_d   = 4'd0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next-state view, so the payload lines up with edge_valid.
    // Counter values 0-7 are luma (LV0..3, LH0..3), 8-11 chroma (CV0, CV1, CH0, CH1).
    always_comb begin
        is_chroma  = cnt_d[3];
        qpq        = is_chroma ? cfg_d.qpc : cfg_d.qpy;
        first_vert = (cnt_d == 4'd0) || (cnt_d == 4'd8);
        first_horz = (cnt_d == 4'd4) || (cnt_d == 4'd10);
        case (cnt_d)
            4'd0:    qpp = cfg_d.qpy_a;
            4'd4:    qpp = cfg_d.qpy_b;
            4'd8:    qpp = cfg_d.qpc_a;
            4'd10:   qpp = cfg_d.qpc_b;
            default: qpp = qpq;
        endcase
        qp_sum = {1'b0, qpp} + {1'b0, qpq} + 7'd1;

        edge_valid_d  = (state_d == EDGE);
        busy_d        = (state_d != IDLE);
        end_d         = (state_d == DONE);
        edge_dir_d    = 1'b0;
        edge_idx_d    = 2'd0;
        edge_chroma_d = 1'b0;
        qpav_d        = 6'd0;
        index_a_d     = 6'd0;
        index_b_d     = 6'd0;
        filter_en_d   = 1'b0;
        if (edge_valid_d) begin
            edge_dir_d    = is_chroma ? cnt_d[1] : cnt_d[2];
            edge_idx_d    = is_chroma ? {1'b0, cnt_d[0]} : cnt_d[1:0];
            edge_chroma_d = is_chroma && CHROMA_EN;
            qpav_d        = qp_sum[6:1];
            index_a_d     = clip_index(qp_sum[6:1], cfg_d.off_a);
            index_b_d     = clip_index(qp_sum[6:1], cfg_d.off_b);
            filter_en_d   = (cfg_d.idc != 2'd1)
                            && !(first_vert && cfg_d.h_zero)
                            && !(first_horz && cfg_d.v_zero);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            cfg_q         <= '0;
            edge_valid_q  <= 1'b0;
            edge_dir_q    <= 1'b0;
            edge_idx_q    <= 2'd0;
            edge_chroma_q <= 1'b0;
            qpav_q        <= 6'd0;
            index_a_q     <= 6'd0;
            index_b_q     <= 6'd0;
            filter_en_q   <= 1'b0;
            busy_q        <= 1'b0;
            end_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cfg_q         <= cfg_d;
            edge_valid_q  <= edge_valid_d;
            edge_dir_q    <= edge_dir_d;
            edge_idx_q    <= edge_idx_d;
            edge_chroma_q <= edge_chroma_d;
            qpav_q        <= qpav_d;
            index_a_q     <= index_a_d;
            index_b_q     <= index_b_d;
            filter_en_q   <= filter_en_d;
            busy_q        <= busy_d;
            end_q         <= end_d;
        end
    end

    assign edge_valid     = edge_valid_q;
    assign edge_dir       = edge_dir_q;
    assign edge_idx       = edge_idx_q;
    assign edge_chroma    = edge_chroma_q;
    assign qPav           = qpav_q;
    assign indexA         = index_a_q;
    assign indexB         = index_b_q;
    assign edge_filter_en = filter_en_q;
    assign busy           = busy_q;
    assign end_of_MB_DF   = end_q;

endmodule

// File: tb/tb_df_qp_edge_seq.sv
// Scoreboard bench for df_qp_edge_seq: a reference model queues expected edges per MB, a monitor checks them.
// Honours DF_QP_CHROMA_EDGES_EN the same way as the design (12 edges when defined, 8 otherwise).
module tb_df_qp_edge_seq;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start_of_MB_DF;
    logic [5:0] QPy, QPc, QPy_addrA, QPc_addrA, QPy_addrB, QPc_addrB;
    logic [7:0] mb_num_h_DF, mb_num_v_DF;
    logic [1:0] disable_deblocking_filter_idc;
    logic [4:0] FilterOffsetA, FilterOffsetB;
    logic       edge_ready;
    logic       edge_valid, edge_dir, edge_chroma, edge_filter_en, busy, end_of_MB_DF;
    logic [1:0] edge_idx;
    logic [5:0] qPav, indexA, indexB;

    always #5 clk = ~clk;

    df_qp_edge_seq dut (
        .clk(clk), .reset_n(reset_n), .start_of_MB_DF(start_of_MB_DF),
        .QPy(QPy), .QPc(QPc), .QPy_addrA(QPy_addrA), .QPc_addrA(QPc_addrA),
        .QPy_addrB(QPy_addrB), .QPc_addrB(QPc_addrB),
        .mb_num_h_DF(mb_num_h_DF), .mb_num_v_DF(mb_num_v_DF),
        .disable_deblocking_filter_idc(disable_deblocking_filter_idc),
        .FilterOffsetA(FilterOffsetA), .FilterOffsetB(FilterOffsetB),
        .edge_ready(edge_ready), .edge_valid(edge_valid), .edge_dir(edge_dir),
        .edge_idx(edge_idx), .edge_chroma(edge_chroma), .qPav(qPav),
        .indexA(indexA), .indexB(indexB), .edge_filter_en(edge_filter_en),
        .busy(busy), .end_of_MB_DF(end_of_MB_DF)
    );

`ifdef DF_QP_CHROMA_EDGES_EN
    localparam int N_EDGES = 12;
`else
    localparam int N_EDGES = 8;
`endif

    typedef struct {
        int qpy, qpc, qpya, qpca, qpyb, qpcb, h, v, idc, offa, offb;
    } mb_cfg_t;

    typedef struct {
        int dir, idx, chroma, qpav, ia, ib, fen;
    } edge_exp_t;

    edge_exp_t exp_q[$];
    int        ends_pending = 0;
    int        n_checks = 0;
    int        n_fail = 0;
    int        cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int clip3(input int lo, input int hi, input int x);
        return (x < lo) ? lo : ((x > hi) ? hi : x);
    endfunction

    // Reference model: one edge from the H.264 rules, expressed in plain integer arithmetic.
    function automatic edge_exp_t make_edge(input mb_cfg_t c, input int chroma, input int dir, input int i);
        edge_exp_t e;
        int qpq, qpp;
        bit on_pic_edge;
        qpq = chroma ? c.qpc : c.qpy;
        qpp = qpq;
        if (i == 0) qpp = chroma ? (dir ? c.qpcb : c.qpca) : (dir ? c.qpyb : c.qpya);
        e.dir    = dir;
        e.idx    = i;
        e.chroma = chroma;
        e.qpav   = (qpp + qpq + 1) / 2;
        e.ia     = clip3(0, 51, e.qpav + c.offa);
        e.ib     = clip3(0, 51, e.qpav + c.offb);
        on_pic_edge = (i == 0) && ((dir == 0 && c.h == 0) || (dir == 1 && c.v == 0));
        e.fen    = (c.idc != 1 && !on_pic_edge) ? 1 : 0;
        return e;
    endfunction

    task automatic push_mb(input mb_cfg_t c);
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++) exp_q.push_back(make_edge(c, 0, d, i));
`ifdef DF_QP_CHROMA_EDGES_EN
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 2; i++) exp_q.push_back(make_edge(c, 1, d, i));
`endif
    endtask

    function automatic mb_cfg_t mk(input int qpy, input int qpc, input int ya, input int ca, input int yb,
                                   input int cb, input int h, input int v, input int idc, input int oa, input int ob);
        mb_cfg_t c;
        c.qpy = qpy; c.qpc = qpc; c.qpya = ya; c.qpca = ca; c.qpyb = yb; c.qpcb = cb;
        c.h = h; c.v = v; c.idc = idc; c.offa = oa; c.offb = ob;
        return c;
    endfunction

    function automatic mb_cfg_t rand_cfg();
        return mk(int'($urandom_range(51, 0)), int'($urandom_range(51, 0)), int'($urandom_range(51, 0)),
                  int'($urandom_range(51, 0)), int'($urandom_range(51, 0)), int'($urandom_range(51, 0)),
                  int'($urandom_range(2, 0)), int'($urandom_range(2, 0)), int'($urandom_range(2, 0)),
                  int'($urandom_range(24, 0)) - 12, int'($urandom_range(24, 0)) - 12);
    endfunction

    task automatic drive_cfg(input mb_cfg_t c);
        QPy = 6'(c.qpy); QPc = 6'(c.qpc);
        QPy_addrA = 6'(c.qpya); QPc_addrA = 6'(c.qpca);
        QPy_addrB = 6'(c.qpyb); QPc_addrB = 6'(c.qpcb);
        mb_num_h_DF = 8'(c.h); mb_num_v_DF = 8'(c.v);
        disable_deblocking_filter_idc = 2'(c.idc);
        FilterOffsetA = 5'(c.offa); FilterOffsetB = 5'(c.offb);
    endtask

    function automatic int out_vec();
        return int'({edge_valid, edge_dir, edge_idx, edge_chroma, qPav, indexA, indexB,
                     edge_filter_en, busy, end_of_MB_DF});
    endfunction

    // Monitor: every presented edge is compared against the scoreboard head; a handshake pops it.
    always @(negedge clk) begin
        if (reset_n) begin
            if (edge_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_edge", out_vec(), 0);
                end else begin
                    check("edge_geometry", int'({edge_dir, edge_idx, edge_chroma}),
                          exp_q[0].dir * 8 + exp_q[0].idx * 2 + exp_q[0].chroma);
                    check("edge_qpav", int'(qPav), exp_q[0].qpav);
                    check("edge_indexA", int'(indexA), exp_q[0].ia);
                    check("edge_indexB", int'(indexB), exp_q[0].ib);
                    check("edge_filter_en", int'(edge_filter_en), exp_q[0].fen);
                    if (edge_ready) void'(exp_q.pop_front());
                end
            end
            if (end_of_MB_DF) begin
                check("end_expected", int'(ends_pending > 0), 1);
                check("end_after_all_edges", exp_q.size(), 0);
                if (ends_pending > 0) ends_pending--;
            end
        end
    end

    // mode: 0 = always ready, 1 = random ready, 2 = stall 5 cycles on LH2.
    task automatic run_mb(input mb_cfg_t c, input int mode, input bit nominal,
                          input bit second_start, input bit reset_lh1);
        int  t_first;
        int  stall_left;
        bit  done;
        stall_left = 5;
        done = 1'b0;
        @(posedge clk); #1;
        drive_cfg(c);
        start_of_MB_DF = 1'b1;
        edge_ready = 1'b1;
        push_mb(c);
        ends_pending++;
        @(posedge clk); #1;
        start_of_MB_DF = 1'b0;
        check("load_no_valid", int'(edge_valid), 0);
        check("load_busy", int'(busy), 1);
        @(posedge clk); #1;
        check("first_valid_latency", int'(edge_valid), 1);
        drive_cfg(rand_cfg());
        t_first = cyc;
        for (int k = 0; k < 300 && !done; k++) begin
            if (end_of_MB_DF) begin
                done = 1'b1;
                if (mode == 0) check("end_latency", cyc - t_first, N_EDGES);
            end else begin
                if (reset_lh1 && edge_valid && edge_dir && !edge_chroma && edge_idx == 2'd1) begin
                    reset_n = 1'b0;
                    #1;
                    check("reset_outputs_zero", out_vec(), 0);
                    exp_q.delete();
                    ends_pending = 0;
                    edge_ready = 1'b0;
                    @(posedge clk); #1;
                    reset_n = 1'b1;
                    repeat (20) @(posedge clk);
                    #1;
                    check("reset_stays_idle", out_vec(), 0);
                    return;
                end
                if (nominal && k == 0) check("nominal_lv0_qpav", int'(qPav), 25);
                if (nominal && k == 1) check("nominal_lv1_qpav", int'(qPav), 30);
                start_of_MB_DF = second_start && (k == 3);
                case (mode)
                    1: edge_ready = ($urandom_range(3, 0) != 0);
                    2: begin
                        if (stall_left > 0 && edge_valid && edge_dir && !edge_chroma && edge_idx == 2'd2) begin
                            edge_ready = 1'b0;
                            stall_left--;
                        end else begin
                            edge_ready = 1'b1;
                        end
                    end
                    default: edge_ready = 1'b1;
                endcase
                @(posedge clk); #1;
            end
        end
        start_of_MB_DF = 1'b0;
        check("mb_completed", int'(done), 1);
        @(posedge clk); #1;
        check("back_to_idle", int'({busy, end_of_MB_DF, edge_valid}), 0);
        if (mode == 2) check("stall_cycles_applied", stall_left, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        start_of_MB_DF = 1'b0;
        edge_ready = 1'b0;
        drive_cfg(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", out_vec(), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset", out_vec(), 0);

        run_mb(mk(30, 30, 20, 30, 30, 30, 1, 1, 0, 0, 0), 0, 1'b1, 1'b0, 1'b0);
        run_mb(mk(28, 33, 17, 40, 9, 22, 1, 1, 0, 3, -2), 2, 1'b0, 1'b0, 1'b0);
        run_mb(mk(50, 45, 50, 45, 50, 45, 1, 1, 0, 12, 0), 0, 1'b0, 1'b0, 1'b0);
        run_mb(mk(2, 2, 2, 2, 2, 2, 1, 1, 0, 0, -12), 0, 1'b0, 1'b0, 1'b0);
        run_mb(mk(26, 29, 31, 24, 18, 35, 0, 0, 0, -4, 5), 0, 1'b0, 1'b0, 1'b0);
        run_mb(mk(26, 29, 31, 24, 18, 35, 5, 7, 1, 0, 0), 1, 1'b0, 1'b0, 1'b0);
        run_mb(mk(35, 37, 12, 49, 40, 3, 2, 3, 2, 6, -6), 0, 1'b0, 1'b0, 1'b1);
        run_mb(mk(22, 24, 40, 10, 5, 51, 4, 4, 0, -12, 12), 0, 1'b0, 1'b1, 1'b0);
        for (int n = 0; n < 25; n++) run_mb(rand_cfg(), 1, 1'b0, 1'b0, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        check("no_pending_end", ends_pending, 0);
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
